// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: receive-side monitor for an 8-digit multiplexed seven-segment scan.
// Watches active-low anodes and {a,b,c,d,e,f,g,dp} cathodes. It reconstructs the code and
// decimal point shown on each digit and flags protocol errors.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_an[7:0]      anodes, active-low, bit i selects digit i
//   i_cath[7:0]    cathodes {Ca..Cg,Dp}, active-low, Ca is bit 7
//   i_err_clr      synchronous clear of the sticky error flags
//   o_digits[39:0] digit i code at [5i+4:5i]
//   o_digit_valid  digit i captured at least once since reset
//   o_dp           decimal point lit per digit
//   o_frame_done   one-cycle pulse once all eight digits have been captured
//   o_err_code     sticky: unrecognised segment pattern captured
//   o_err_anode    sticky: more than one anode low seen
module ssd_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_an,
    input  logic [7:0]  i_cath,
    input  logic        i_err_clr,
    output logic [39:0] o_digits,
    output logic [7:0]  o_digit_valid,
    output logic [7:0]  o_dp,
    output logic        o_frame_done,
    output logic        o_err_code,
    output logic        o_err_anode
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]       LP_CODE_OFF = 5'h10;
    localparam logic [4:0]       LP_CODE_BAD = 5'h1F;

    // Synchronizers and previous-sample registers
    logic [7:0]       r_an_meta;
    logic [7:0]       r_an_sync;
    logic [7:0]       r_cath_meta;
    logic [7:0]       r_cath_sync;
    logic [7:0]       r_prev_an;
    logic [7:0]       r_prev_cath;

    // FSM state
    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_k;
    logic [2:0]       w_k_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Datapath registers
    logic [4:0]       r_digit [8];
    logic [7:0]       r_valid;
    logic [7:0]       r_dp;
    logic [7:0]       r_seen;
    logic             r_frame_done;
    logic             r_err_code;
    logic             r_err_anode;

    logic [3:0]       w_zeros;
    logic [2:0]       w_low_idx;
    logic             w_changed;
    logic             w_capture;
    logic             w_anode_err;
    logic [4:0]       w_code;
    logic [7:0]       w_cap_mask;
    logic [7:0]       w_seen_next;
    logic             w_frame;

    // Two-flop synchronizers; idle level is all-ones so reset looks like "no digit selected"
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an_meta   <= 8'hFF;
            r_an_sync   <= 8'hFF;
            r_cath_meta <= 8'hFF;
            r_cath_sync <= 8'hFF;
        end else begin
            r_an_meta   <= i_an;
            r_an_sync   <= r_an_meta;
            r_cath_meta <= i_cath;
            r_cath_sync <= r_cath_meta;
        end
    end

    // Segment decode of abcdefg (active-low)
    always_comb begin
        w_code = LP_CODE_BAD;
        case (r_cath_sync[7:1])
            7'b0000001: w_code = 5'h00;
            7'b1001111: w_code = 5'h01;
            7'b0010010: w_code = 5'h02;
            7'b0000110: w_code = 5'h03;
            7'b1001100: w_code = 5'h04;
            7'b0100100: w_code = 5'h05;
            7'b0100000: w_code = 5'h06;
            7'b0001111: w_code = 5'h07;
            7'b0000000: w_code = 5'h08;
            7'b0000100: w_code = 5'h09;
            7'b0001000: w_code = 5'h0A;
            7'b1100000: w_code = 5'h0B;
            7'b0110001: w_code = 5'h0C;
            7'b1000010: w_code = 5'h0D;
            7'b0110000: w_code = 5'h0E;
            7'b0111000: w_code = 5'h0F;
            7'b1111111: w_code = 5'h10;
            7'b1000100: w_code = 5'h11;
            7'b0000010: w_code = 5'h12;
            7'b1110001: w_code = 5'h13;
            default:    w_code = LP_CODE_BAD;
        endcase
    end

    // Count low anodes and remember which one (only meaningful when exactly one is low)
    always_comb begin
        w_zeros   = 4'd0;
        w_low_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_an_sync[i]) begin
                w_zeros   = w_zeros + 4'd1;
                w_low_idx = 3'(i);
            end
        end
    end

    assign w_changed = (r_an_sync != r_prev_an) || (r_cath_sync != r_prev_cath);

    // Next-state logic. "Re-evaluate" starts a fresh settle from the current anode pattern,
    // which also covers a cathode-only change (same digit index, counter restarted).
    always_comb begin
        logic w_eval;
        w_state_next = r_state;
        w_k_next     = r_k;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_anode_err  = 1'b0;
        w_eval       = 1'b0;

        case (r_state)
            StIdle: w_eval = 1'b1;
            StSettle: begin
                if (w_changed) begin
                    w_eval = 1'b1;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = StHold;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StHold: begin
                if (w_changed) w_eval = 1'b1;
            end
            default: w_state_next = StIdle;
        endcase

        if (w_eval) begin
            w_cnt_next = '0;
            if (w_zeros == 4'd0) begin
                w_state_next = StIdle;
            end else if (w_zeros == 4'd1) begin
                w_state_next = StSettle;
                w_k_next     = w_low_idx;
            end else begin
                w_state_next = StIdle;
                w_anode_err  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_k         <= 3'd0;
            r_cnt       <= '0;
            r_prev_an   <= 8'hFF;
            r_prev_cath <= 8'hFF;
        end else begin
            r_state     <= w_state_next;
            r_k         <= w_k_next;
            r_cnt       <= w_cnt_next;
            r_prev_an   <= r_an_sync;
            r_prev_cath <= r_cath_sync;
        end
    end

    // Frame tracking: a completed mask pulses frame_done one edge later and restarts, keeping
    // any capture that lands on that same edge as the first member of the new frame.
    always_comb begin
        w_cap_mask  = w_capture ? (8'h01 << r_k) : 8'h00;
        w_frame     = (r_seen == 8'hFF);
        w_seen_next = w_frame ? w_cap_mask : (r_seen | w_cap_mask);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) r_digit[i] <= LP_CODE_OFF;
            r_valid      <= 8'h00;
            r_dp         <= 8'h00;
            r_seen       <= 8'h00;
            r_frame_done <= 1'b0;
            r_err_code   <= 1'b0;
            r_err_anode  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_digit[r_k] <= w_code;
                r_dp[r_k]    <= ~r_cath_sync[0];
                r_valid[r_k] <= 1'b1;
            end
            r_seen       <= w_seen_next;
            r_frame_done <= w_frame;
            // A new error on the same edge as a clear keeps the flag set
            if (w_capture && (w_code == LP_CODE_BAD)) r_err_code <= 1'b1;
            else if (i_err_clr)                       r_err_code <= 1'b0;
            if (w_anode_err)    r_err_anode <= 1'b1;
            else if (i_err_clr) r_err_anode <= 1'b0;
        end
    end

    always_comb begin
        o_digits = '0;
        for (int i = 0; i < 8; i++) o_digits[5*i +: 5] = r_digit[i];
    end

    assign o_digit_valid = r_valid;
    assign o_dp          = r_dp;
    assign o_frame_done  = r_frame_done;
    assign o_err_code    = r_err_code;
    assign o_err_anode   = r_err_anode;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench for ssd_scan_decoder. Stimulus pushes expected digit-register snapshots and
// frame pulses (with their cycle) into queues; a negedge monitor pops them whenever the DUT
// outputs change or frame_done is high.
module tb_ssd_scan_decoder;

    localparam int unsigned SETTLE = 16;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  an      = 8'hFF;
    logic [7:0]  cath    = 8'hFF;
    logic        err_clr = 1'b0;
    logic [39:0] o_digits;
    logic [7:0]  o_digit_valid;
    logic [7:0]  o_dp;
    logic        o_frame_done;
    logic        o_err_code;
    logic        o_err_anode;

    ssd_scan_decoder #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_an         (an),
        .i_cath       (cath),
        .i_err_clr    (err_clr),
        .o_digits     (o_digits),
        .o_digit_valid(o_digit_valid),
        .o_dp         (o_dp),
        .o_frame_done (o_frame_done),
        .o_err_code   (o_err_code),
        .o_err_anode  (o_err_anode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] digits;
        logic [7:0]  dp;
        logic [7:0]  valid;
        int          at;
    } upd_t;

    upd_t upd_q[$];
    int   frame_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected-state model
    logic [4:0] m_dig [8];
    logic [7:0] m_dp;
    logic [7:0] m_valid;
    logic [7:0] m_seen;

    // Hand-computed cathode bytes: frame 1 codes 0..7 (Dp lit on digit 5), frame 2 codes 8..F
    logic [7:0] f1_cath [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h48, 8'h41, 8'h1F};
    logic [7:0] f2_cath [8] = '{8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    logic [4:0] f1_code [8] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07};
    logic [4:0] f2_code [8] = '{5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] model_digits();
        logic [39:0] d;
        for (int i = 0; i < 8; i++) d[5*i +: 5] = m_dig[i];
        return d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 5'h10;
        m_dp    = 8'h00;
        m_valid = 8'h00;
        m_seen  = 8'h00;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_digits"}, 64'(o_digits), {24'h0, {8{5'h10}}});
        check({tag, "_valid"}, 64'(o_digit_valid), 64'h0);
        check({tag, "_dp"}, 64'(o_dp), 64'h0);
        check({tag, "_frame"}, 64'(o_frame_done), 64'h0);
        check({tag, "_err_code"}, 64'(o_err_code), 64'h0);
        check({tag, "_err_anode"}, 64'(o_err_anode), 64'h0);
    endtask

    // Called at a negedge: drive a pattern, optionally expect a capture, hold for dwell cycles.
    // A capture for inputs first sampled at posedge n+1 is visible at the negedge of cycle
    // n+3+SETTLE; a completing capture's frame pulse one cycle later.
    task automatic scan(input logic [7:0] a, input logic [7:0] c, input int dwell,
                        input bit cap, input int idx, input logic [4:0] code);
        upd_t u;
        int   n;
        an   = a;
        cath = c;
        n    = cyc;
        if (cap) begin
            m_dig[idx]   = code;
            m_dp[idx]    = ~c[0];
            m_valid[idx] = 1'b1;
            u.digits     = model_digits();
            u.dp         = m_dp;
            u.valid      = m_valid;
            u.at         = n + SETTLE + 3;
            upd_q.push_back(u);
            m_seen[idx] = 1'b1;
            if (m_seen == 8'hFF) begin
                frame_q.push_back(n + SETTLE + 4);
                m_seen = 8'h00;
            end
        end
        repeat (dwell) @(negedge clk);
    endtask

    // Monitor
    logic [55:0] prev_snap;
    always @(negedge clk) begin : mon
        logic [55:0] snap;
        upd_t        u;
        int          f;
        snap = {o_digits, o_dp, o_digit_valid};
        if (!rst_n) begin
            prev_snap = snap;
        end else begin
            if (snap !== prev_snap) begin
                if (upd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_update: got %0h, expected no change from %0h",
                             snap, prev_snap);
                end else begin
                    u = upd_q.pop_front();
                    check("update_value", 64'(snap), 64'({u.digits, u.dp, u.valid}));
                    check("update_cycle", 64'(cyc), 64'(u.at));
                end
                prev_snap = snap;
            end
            if (o_frame_done) begin
                if (frame_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got 1 at cycle %0d, expected 0", cyc);
                end else begin
                    f = frame_q.pop_front();
                    check("frame_cycle", 64'(cyc), 64'(f));
                end
            end
        end
    end

    initial begin
        logic [7:0] a_v;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset("reset");

        // Idle after reset: no frame pulse, no updates
        scan(8'hFF, 8'hFF, 60, 1'b0, 0, 5'h0);

        // Single digit "3" with Dp lit, held 40 cycles
        scan(8'hFE, 8'h0C, 40, 1'b1, 0, 5'h03);
        check("single_valid", 64'(o_digit_valid), 64'h01);

        // Two full frames
        for (int i = 0; i < 8; i++) begin
            a_v    = 8'hFF;
            a_v[i] = 1'b0;
            scan(a_v, f1_cath[i], 20, 1'b1, i, f1_code[i]);
        end
        check("frame1_dp", 64'(o_dp), 64'h20);
        for (int i = 0; i < 8; i++) begin
            a_v    = 8'hFF;
            a_v[i] = 1'b0;
            scan(a_v, f2_cath[i], 20, 1'b1, i, f2_code[i]);
        end
        check("frame2_valid", 64'(o_digit_valid), 64'hFF);

        // Glitch: "3" abandoned at cnt=10, then "8" captured
        scan(8'hFD, 8'h0D, 10, 1'b0, 1, 5'h0);
        scan(8'hFD, 8'h01, 20, 1'b1, 1, 5'h08);

        // Bad segment pattern
        scan(8'hFB, 8'h55, 20, 1'b1, 2, 5'h1F);
        check("err_code_set", 64'(o_err_code), 64'h1);
        check("err_anode_clear", 64'(o_err_anode), 64'h0);

        // Two anodes low
        scan(8'hFC, 8'h55, 20, 1'b0, 0, 5'h0);
        check("err_anode_set", 64'(o_err_anode), 64'h1);
        scan(8'hFF, 8'hFF, 5, 1'b0, 0, 5'h0);
        check("err_anode_sticky", 64'(o_err_anode), 64'h1);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_err_code", 64'(o_err_code), 64'h0);
        check("clr_err_anode", 64'(o_err_anode), 64'h0);

        // err_clr on the same edge as a new bad capture
        scan(8'hF7, 8'h55, SETTLE + 2, 1'b1, 3, 5'h1F);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_vs_new_err", 64'(o_err_code), 64'h1);
        repeat (3) @(negedge clk);

        // Reset at cnt=8 of a settle, then release with inputs held
        scan(8'hEF, 8'h49, 11, 1'b0, 4, 5'h0);
        #2 rst_n = 1'b0;
        #1 check_reset("midreset");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        scan(8'hEF, 8'h49, 30, 1'b1, 4, 5'h05);
        check("midreset_valid", 64'(o_digit_valid), 64'h10);
        scan(8'hFF, 8'hFF, 55, 1'b0, 0, 5'h0);

        while (upd_q.size() != 0) begin
            void'(upd_q.pop_front());
            n_tests++;
            n_fail++;
            $display("FAIL missing_update: got none, expected a digit capture");
        end
        while (frame_q.size() != 0) begin
            void'(frame_q.pop_front());
            n_tests++;
            n_fail++;
            $display("FAIL missing_frame_done: got none, expected a frame pulse");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Receive-side decoder for the board's 8-digit multiplexed seven-segment scan: active-low anodes plus {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp} cathodes. It reconstructs the 5-bit digit code and decimal point held on each of the eight digits. The block sits beside the display driver, or on a second board's Pmod, as a self-check/debug monitor. It provides per-digit registers, a frame-complete strobe, and sticky protocol error flags.

## Interface
- SETTLE_CYCLES, 16, Clk cycles an anode/cathode pair must be stable before capture (legal range ≥2)
- CNT_W, 8, width of settle counter (2^CNT_W > SETTLE_CYCLES)

- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- An  in  8  anodes, active-low; An[i] selects digit i
- Cath  in  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, Ca is bit 7
- err_clr  in  1  synchronous clear of sticky errors
- digits  out  40  digit i code at [5i+4:5i]
- digit_valid  out  8  digit i captured at least once since reset
- dp  out  8  dp[i]=1 when digit i decimal point lit (Dp low)
- frame_done  out  1  one-cycle pulse, all 8 digits captured since last pulse
- err_code  out  1  sticky: unrecognised segment pattern captured
- err_anode  out  1  sticky: more than one anode low seen

## Operation
- An, Cath pass through 2-flop synchronizers (reset to all-ones); all logic uses the synchronized values sA, sC.
- Segment decode on sC[7:1] (abcdefg):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 0110000→E, 0111000→F
  - 1111111→5'h10 (OFF), 1000100→5'h11 (Y), 0000010→5'h12 (a), 1110001→5'h13 (L)
  - anything else→5'h1F
- FSM states IDLE, SETTLE, HOLD; registers k (3-bit anode index), cnt, prevA, prevC.
  - IDLE: sA all-ones → stay. sA has exactly one zero → SETTLE, k=index, cnt=0. Two or more zeros → stay, set err_anode.
  - SETTLE: sA≠prevA or sC≠prevC → re-evaluate as from IDLE (cnt=0). Else cnt+1. At cnt==SETTLE_CYCLES-1 with inputs unchanged → capture, HOLD.
  - Capture: digits[k]=decode, dp[k]=~sC[0], digit_valid[k]=1, seen[k]=1; set err_code if decode==5'h1F.
  - HOLD: inputs unchanged → stay, no recapture. sA change → re-evaluate as from IDLE. sC change only → SETTLE, cnt=0, same k.
- Frame: 8-bit seen mask. On the edge after a capture makes seen==8'hFF, frame_done=1 and seen=0. A capture on that same edge sets its own seen bit in the new frame.
- err_clr clears both sticky flags. A same-cycle new error wins: the flag stays 1.

## Timing
- Reset values:
  - digits all 5'h10; digit_valid=0, dp=0, frame_done=0, err_code=0, err_anode=0
  - FSM=IDLE, seen=0, cnt=0, synchronizers all-ones
- Reset is asynchronous assert, deasserted synchronously by the system. Reset mid-SETTLE/HOLD discards progress.
- Latency: An/Cath stable from edge E → synchronized at E+2, SETTLE entered at E+2 with cnt=0, digit registers update at edge E+2+SETTLE_CYCLES.
- Frame timing: frame_done goes high at edge E+3+SETTLE_CYCLES of the completing capture and lasts exactly 1 cycle.
- Dwell shorter than SETTLE_CYCLES+1 synchronized cycles never captures.
- Recapture of an unchanged digit requires an intervening anode change.
- err_anode is set on the first edge where sA has ≥2 zeros; no capture occurs in that state.

## Test plan
- Reset: assert Reset=0 mid-run → all outputs at reset values immediately; no frame_done for ≥50 cycles after release with An=8'hFF.
- Single digit, SETTLE_CYCLES=16: An=8'hFE, Cath=8'b00001100 from edge E, held 40 cycles → digits[4:0]=3 and digit_valid=8'h01 exactly at E+18; no further updates.
- Full frame: digits 0..7 each driven 20 cycles with codes 0..7, Dp lit on digit 5 only → frame_done pulses once, 1 cycle, 1 edge after digit 7 capture; dp=8'h20; second frame gives a second single pulse.
- Glitch: Cath changes from "3" to "8" at cnt=10 → no capture of 3; digit captures 8 at 16+1 cycles after the change reaches sC.
- Errors: Cath=8'b01010101 held → digit code 5'h1F, err_code=1. An=8'hFC → err_anode=1, no digit change. err_clr pulse clears both flags. err_clr coincident with a new bad capture → err_code stays 1.
- Mid-operation reset: Reset low at cnt=8 of a settle, then released with inputs unchanged → capture only after a full 2+SETTLE_CYCLES from release.
